// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU codes, RV32I opcode/funct constants and the registered issue payload.
// Imported by the issue stage, its immediate generator and the interface.
// Codes match the encoding the downstream alu decodes.
package alu_issue_stage_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 4;

  typedef enum logic [CTRL_W-1:0] {
    ALU_DUM = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_SLL = 4'd3,
    ALU_SLT = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_OR  = 4'd8,
    ALU_AND = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    alu_op_e         op;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
  } issue_t;

  // funct3 -> ALU code; alt selects sub/sra. Legality is checked by the caller.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  f3_to_op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  f3_to_op = ALU_SLL;
      F3_SLT:  f3_to_op = ALU_SLT;
      F3_XOR:  f3_to_op = ALU_XOR;
      F3_SR:   f3_to_op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   f3_to_op = ALU_OR;
      F3_AND:  f3_to_op = ALU_AND;
      default: f3_to_op = ALU_DUM;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream instruction handshake plus downstream ALU operand handshake.
// master = the surrounding pipeline (drives instr, consumes operands); slave = the stage.
// No clock inside; clk/rst are plain ports of the stage.
interface alu_issue_stage_if;
  import alu_issue_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   instr;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   r1;
  logic [XLEN-1:0]   r2;
  logic [CTRL_W-1:0] alu_control_decode;
  logic [4:0]        rd;
  logic              reg_write;
  logic              illegal;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, r1, r2, alu_control_decode, rd, reg_write, illegal
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, r1, r2, alu_control_decode, rd, reg_write, illegal
  );
endinterface

// File: rtl/alu_issue_stage_imm_gen.sv
// Immediate generator: instr -> sign-extended I/S/U immediates and zero-extended shamt.
// Purely combinational, no latency.
// No handshake; consumed by the decoder in the same cycle.
module alu_issue_stage_imm_gen
  import alu_issue_stage_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] i_imm_o,
  output logic [XLEN-1:0] s_imm_o,
  output logic [XLEN-1:0] u_imm_o,
  output logic [XLEN-1:0] shamt_o
);
  assign i_imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
  assign s_imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign u_imm_o = {instr_i[31:12], 12'b0};
  assign shamt_o = {27'b0, instr_i[24:20]};
endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I instr + regfile data into ALU operands/code, one register.
// Latency 1 cycle; full throughput (drain and accept on the same edge).
// in_ready = !out_valid || out_ready; flush kills held and incoming entries.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  alu_issue_stage_if.slave   bus_if
);
  logic [XLEN-1:0] i_imm, s_imm, u_imm, shamt;
  issue_t          dec;
  issue_t          payload_q;
  logic            valid_q, valid_d;
  logic            take;
  logic            legal;

  wire [6:0] opcode = bus_if.instr[6:0];
  wire [2:0] f3     = bus_if.instr[14:12];
  wire [6:0] f7     = bus_if.instr[31:25];

  alu_issue_stage_imm_gen u_imm_gen (
    .instr_i (bus_if.instr),
    .i_imm_o (i_imm),
    .s_imm_o (s_imm),
    .u_imm_o (u_imm),
    .shamt_o (shamt)
  );

  // Decode the incoming instruction into the payload it would register.
  always_comb begin
    dec           = '0;
    dec.rd        = bus_if.instr[11:7];
    dec.r1        = bus_if.rs1_data;
    dec.r2        = bus_if.rs2_data;
    dec.op        = ALU_ADD;
    dec.reg_write = 1'b1;
    legal         = 1'b1;
    case (opcode)
      OPC_OP: begin
        legal  = ((f7 == F7_ZERO) && (f3 != F3_SLTU)) ||
                 ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
        dec.op = f3_to_op(f3, f7[5]);
      end
      OPC_OP_IMM: begin
        legal  = (f3 != F3_SLTU) &&
                 ((f3 != F3_SLL) || (f7 == F7_ZERO)) &&
                 ((f3 != F3_SR) || (f7 == F7_ZERO) || (f7 == F7_ALT));
        dec.op = f3_to_op(f3, (f3 == F3_SR) && f7[5]);
        dec.r2 = ((f3 == F3_SLL) || (f3 == F3_SR)) ? shamt : i_imm;
      end
      OPC_LUI: begin
        dec.r1 = '0;
        dec.r2 = u_imm;
      end
      OPC_AUIPC: begin
        dec.r1 = bus_if.pc;
        dec.r2 = u_imm;
      end
      OPC_JAL, OPC_JALR: begin
        dec.r1 = bus_if.pc;
        dec.r2 = 32'd4;
      end
      OPC_LOAD: begin
        dec.r2 = i_imm;
      end
      OPC_STORE: begin
        dec.r2        = s_imm;
        dec.reg_write = 1'b0;
      end
      OPC_BRANCH: begin
        dec.op        = ALU_SUB;
        dec.reg_write = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.r1        = '0;
      dec.r2        = '0;
      dec.op        = ALU_DUM;
      dec.reg_write = 1'b0;
    end
    dec.illegal = !legal;
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  assign bus_if.in_ready = !valid_q || bus_if.out_ready;
  assign take            = bus_if.in_valid && bus_if.in_ready && !bus_if.flush;

  // Valid next-state: flush wins, then a new transfer, then drain.
  always_comb begin
    valid_d = valid_q;
    if (bus_if.flush)                     valid_d = 1'b0;
    else if (take)                        valid_d = 1'b1;
    else if (valid_q && bus_if.out_ready) valid_d = 1'b0;
  end

  // Pipeline register; payload only changes on an accepted transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (take) payload_q <= dec;
    end
  end

  assign bus_if.out_valid          = valid_q;
  assign bus_if.r1                 = payload_q.r1;
  assign bus_if.r2                 = payload_q.r2;
  assign bus_if.alu_control_decode = payload_q.op;
  assign bus_if.rd                 = payload_q.rd;
  assign bus_if.reg_write          = payload_q.reg_write;
  assign bus_if.illegal            = payload_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table applied back-to-back,
// then hand-written hold, drain, flush and reset sequences.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic [3:0]  e_code;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_ill;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.in_valid = 1'b1;
    bus.instr    = instr;
    bus.pc       = pc;
    bus.rs1_data = rs1;
    bus.rs2_data = rs2;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [3:0] code, input logic [4:0] rd,
                         input logic rw, input logic ill);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".r1"}, bus.r1, r1);
    chk({tag, ".r2"}, bus.r2, r2);
    chk({tag, ".code"}, 32'(bus.alu_control_decode), 32'(code));
    chk({tag, ".rd"}, 32'(bus.rd), 32'(rd));
    chk({tag, ".reg_write"}, 32'(bus.reg_write), 32'(rw));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
  endtask

  initial begin
    // instr, pc, rs1, rs2 -> r1, r2, code, rd, reg_write, illegal
    vecs.push_back('{32'hFFF08293, 0, 32'h10, 0, 32'h10, 32'hFFFFFFFF, 4'd1, 5'd5, 1, 0});       // addi x5,x1,-1
    vecs.push_back('{32'h402081B3, 0, 7, 3, 7, 3, 4'd2, 5'd3, 1, 0});                            // sub
    vecs.push_back('{32'h40315093, 0, 32'h80000000, 9, 32'h80000000, 3, 4'd7, 5'd1, 1, 0});      // srai
    vecs.push_back('{32'h0020B1B3, 0, 5, 6, 0, 0, 4'd0, 5'd3, 0, 1});                            // sltu illegal
    vecs.push_back('{32'h123453B7, 0, 32'hDEAD, 1, 0, 32'h12345000, 4'd1, 5'd7, 1, 0});          // lui
    vecs.push_back('{32'h00508013, 0, 32'h20, 0, 32'h20, 5, 4'd1, 5'd0, 0, 0});                  // addi x0
    vecs.push_back('{32'hABCDE117, 32'h1000, 1, 2, 32'h1000, 32'hABCDE000, 4'd1, 5'd2, 1, 0});   // auipc
    vecs.push_back('{32'h008000EF, 32'h2000, 1, 2, 32'h2000, 4, 4'd1, 5'd1, 1, 0});              // jal
    vecs.push_back('{32'hFE20AE23, 0, 32'h100, 7, 32'h100, 32'hFFFFFFFC, 4'd1, 5'd28, 0, 0});    // sw -4
    vecs.push_back('{32'h00208463, 0, 9, 9, 9, 9, 4'd2, 5'd8, 0, 0});                            // beq
    vecs.push_back('{32'hFF80A203, 0, 32'h40, 0, 32'h40, 32'hFFFFFFF8, 4'd1, 5'd4, 1, 0});       // lw -8
    vecs.push_back('{32'h02109093, 0, 1, 1, 0, 0, 4'd0, 5'd1, 0, 1});                            // slli bad f7
    vecs.push_back('{32'h0000007F, 0, 1, 1, 0, 0, 4'd0, 5'd0, 0, 1});                            // bad opcode
    vecs.push_back('{32'h0020C333, 0, 32'hF0, 32'h0F, 32'hF0, 32'h0F, 4'd5, 5'd6, 1, 0});        // xor
    vecs.push_back('{32'h01F15093, 0, 32'h55, 0, 32'h55, 31, 4'd6, 5'd1, 1, 0});                 // srli 31
    vecs.push_back('{32'h0020F533, 0, 3, 5, 3, 5, 4'd9, 5'd10, 1, 0});                           // and
    vecs.push_back('{32'h4020D2B3, 0, 8, 2, 8, 2, 4'd7, 5'd5, 1, 0});                            // sra
    vecs.push_back('{32'h402091B3, 0, 8, 2, 0, 0, 4'd0, 5'd3, 0, 1});                            // f7=20 f3=001 illegal

    bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_out("reset", 0, 0, 0, 4'd0, 5'd0, 0, 0);
    chk("reset.in_ready", 32'(bus.in_ready), 1);

    // Table applied one per cycle with out_ready held high: full throughput.
    foreach (vecs[i]) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      tick();
      chk_out($sformatf("vec%0d", i), 1, vecs[i].e_r1, vecs[i].e_r2, vecs[i].e_code,
              vecs[i].e_rd, vecs[i].e_rw, vecs[i].e_ill);
      chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 1);
    end

    // Hold: entry ADDI stays put for 3 cycles while a different instr waits upstream.
    drive(32'hFFF08293, 0, 32'h10, 0);
    tick();
    bus.out_ready = 1'b0;
    drive(32'h402081B3, 0, 7, 3);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out($sformatf("hold%0d", c), 1, 32'h10, 32'hFFFFFFFF, 4'd1, 5'd5, 1, 0);
      chk($sformatf("hold%0d.in_ready", c), 32'(bus.in_ready), 0);
    end
    // Release: the waiting SUB is accepted on the draining edge.
    bus.out_ready = 1'b1;
    #1 chk("release.in_ready", 32'(bus.in_ready), 1);
    tick();
    chk_out("release", 1, 7, 3, 4'd2, 5'd3, 1, 0);

    // Drain with nothing new: valid drops, payload unchanged.
    bus.in_valid = 1'b0;
    tick();
    chk_out("drain", 0, 7, 3, 4'd2, 5'd3, 1, 0);

    // Flush with an incoming transfer: nothing captured.
    drive(32'h123453B7, 0, 0, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_in.out_valid", 32'(bus.out_valid), 0);
    chk("flush_in.r2", bus.r2, 3);

    // Flush overrides hold.
    tick();
    chk("load.out_valid", 32'(bus.out_valid), 1);
    chk("load.r2", bus.r2, 32'h12345000);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    tick();
    chk("pre_flush_hold.out_valid", 32'(bus.out_valid), 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_hold.out_valid", 32'(bus.out_valid), 0);

    // Reset mid-hold returns every output to its reset value.
    drive(32'h0020F533, 0, 3, 5);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("pre_rst.out_valid", 32'(bus.out_valid), 1);
    rst = 1'b1;
    bus.flush = 1'b1;
    tick();
    rst = 1'b0;
    bus.flush = 1'b0;
    chk_out("rst_hold", 0, 0, 0, 4'd0, 5'd0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
